// File: rtl/deskew_ctrl_rx_pkg.sv
// Shared PCS constants and the deskew controller state type.
package deskew_ctrl_rx_pkg;

  localparam int LANE_N           = 4;
  localparam int BLOCK_W          = 66;
  localparam int MAX_SKEW_BIT_N   = 1856;
  // One block of margin is reserved for marker-phase uncertainty.
  localparam int MAX_SKEW_BLOCK_N = (MAX_SKEW_BIT_N - BLOCK_W - 1) / BLOCK_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    ALIGNED = 2'd2
  } deskew_state_e;

endpackage

// File: rtl/deskew_ctrl_rx_if.sv
// Bus between the lane marker front end and the deskew controller.
interface deskew_ctrl_rx_if
  import deskew_ctrl_rx_pkg::*;
#(
  parameter int LANE_N = 4,
  parameter int DLY_W  = 5
);
  // valid_i qualifies one block slot; there is no back-pressure, every
  // output is a level or a one-cycle pulse observed on every cycle.
  logic                      valid_i;
  logic [LANE_N-1:0]         am_v_i;
  logic [LANE_N-1:0]         am_lock_lost_v_i;
  logic [LANE_N*DLY_W-1:0]   delay_sel_o;
  logic                      align_v_o;
  logic                      align_err_o;
  logic                      deskew_rst_o;
  deskew_state_e             state_dbg;

  modport master (
    output valid_i, am_v_i, am_lock_lost_v_i,
    input  delay_sel_o, align_v_o, align_err_o, deskew_rst_o, state_dbg
  );

  modport slave (
    input  valid_i, am_v_i, am_lock_lost_v_i,
    output delay_sel_o, align_v_o, align_err_o, deskew_rst_o, state_dbg
  );
endinterface

// File: rtl/deskew_ctrl_lane_rx.sv
// Per-lane marker capture: remembers whether and when this lane's marker arrived.
module deskew_ctrl_lane_rx #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cap_en,
  input  logic             am_v,
  input  logic [CNT_W-1:0] cnt_val,
  output logic             captured,
  output logic [CNT_W-1:0] arr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      captured <= 1'b0;
      arr      <= '0;
    end else if (start) begin
      captured <= am_v;
      arr      <= '0;
    end else if (cap_en && am_v && !captured) begin
      // Only the first marker of a measurement window counts.
      captured <= 1'b1;
      arr      <= cnt_val;
    end
  end

endmodule

// File: rtl/deskew_ctrl_rx.sv
// Measures inter-lane marker skew and produces per-lane delay selects.
module deskew_ctrl_rx #(
  parameter int LANE_N           = deskew_ctrl_rx_pkg::LANE_N,
  parameter int MAX_SKEW_BLOCK_N = deskew_ctrl_rx_pkg::MAX_SKEW_BLOCK_N,
  parameter int DLY_W            = 5
) (
  input  logic             clk,
  input  logic             reset,
  deskew_ctrl_rx_if.slave  bus
);
  import deskew_ctrl_rx_pkg::*;

  // One spare bit so the saturation value never wraps for any legal DLY_W.
  localparam int              CNT_W   = DLY_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SKEW_BLOCK_N);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_SKEW_BLOCK_N + 1);

  deskew_state_e       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                err_q, err_d, drst_q, drst_d;
  logic                lane_start, lane_cap_en;
  logic                lost_any, all_done;
  logic [LANE_N-1:0]   captured;
  logic [CNT_W-1:0]    arr [LANE_N];
  logic [CNT_W-1:0]    diff;
  logic [LANE_N*DLY_W-1:0] delay_sel;

  assign lost_any = |bus.am_lock_lost_v_i;
  assign all_done = &(captured | bus.am_v_i);
  assign cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    drst_d      = 1'b0;
    lane_start  = 1'b0;
    lane_cap_en = 1'b0;
    if (bus.valid_i) begin
      case (state_q)
        IDLE: begin
          if (|bus.am_v_i) begin
            lane_start = 1'b1;
            cnt_d      = '0;
            state_d    = (&bus.am_v_i) ? ALIGNED : COUNT;
          end
        end
        COUNT: begin
          // Lock loss outranks both the skew limit and completion.
          if (lost_any) begin
            state_d = IDLE;
            drst_d  = 1'b1;
          end else if (cnt_inc > CNT_MAX) begin
            state_d = IDLE;
            err_d   = 1'b1;
            drst_d  = 1'b1;
          end else begin
            cnt_d       = cnt_inc;
            lane_cap_en = 1'b1;
            if (all_done) state_d = ALIGNED;
          end
        end
        ALIGNED: begin
          if (lost_any) begin
            state_d = IDLE;
            drst_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      drst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      drst_q  <= drst_d;
    end
  end

  for (genvar i = 0; i < LANE_N; i++) begin : g_lane
    deskew_ctrl_lane_rx #(.CNT_W(CNT_W)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .start    (lane_start),
      .cap_en   (lane_cap_en),
      .am_v     (bus.am_v_i[i]),
      .cnt_val  (cnt_inc),
      .captured (captured[i]),
      .arr      (arr[i])
    );
  end

  // The latest lane arrived at cnt_q, so its delay is zero.
  always_comb begin
    delay_sel = '0;
    diff      = '0;
    for (int i = 0; i < LANE_N; i++) begin
      diff = cnt_q - arr[i];
      if (state_q == ALIGNED) delay_sel[i*DLY_W +: DLY_W] = diff[DLY_W-1:0];
    end
  end

  assign bus.delay_sel_o  = delay_sel;
  assign bus.align_v_o    = (state_q == ALIGNED);
  assign bus.align_err_o  = err_q;
  assign bus.deskew_rst_o = drst_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_deskew_ctrl_rx.sv
// Randomized and directed bench for deskew_ctrl_rx with an event scoreboard.
module tb_deskew_ctrl_rx;
  localparam int LANE_N = 4;
  localparam int DLY_W  = 5;
  localparam int MAX    = deskew_ctrl_rx_pkg::MAX_SKEW_BLOCK_N;
  localparam int DW     = LANE_N * DLY_W;
  localparam int W      = 3 + DW + 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  deskew_ctrl_rx_if #(.LANE_N(LANE_N), .DLY_W(DLY_W)) bus ();

  deskew_ctrl_rx #(.LANE_N(LANE_N), .MAX_SKEW_BLOCK_N(MAX), .DLY_W(DLY_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Event word: {align_err, deskew_rst, align_v rising, delays, cycle seen}.
  logic [W-1:0] exp_q[$];
  bit  m_hunt, m_lock;
  int  m_vcnt;
  int  m_arr[LANE_N];

  task automatic push_ev(input logic [2:0] k, input logic [DW-1:0] d, input int c);
    exp_q.push_back({k, d, 16'(c + 1)});
  endtask

  function automatic logic [DW-1:0] model_delays();
    logic [DW-1:0] d;
    int mx;
    d  = '0;
    mx = 0;
    for (int i = 0; i < LANE_N; i++) if (m_arr[i] > mx) mx = m_arr[i];
    for (int i = 0; i < LANE_N; i++) d[i*DLY_W +: DLY_W] = DLY_W'(mx - m_arr[i]);
    return d;
  endfunction

  function automatic bit all_arrived();
    for (int i = 0; i < LANE_N; i++) if (m_arr[i] < 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input logic v, input logic [LANE_N-1:0] am,
                            input logic [LANE_N-1:0] lost, input int c);
    if (!v) return;
    if (m_lock) begin
      if (lost != 0) begin push_ev(3'b010, '0, c); m_lock = 0; end
    end else if (m_hunt) begin
      if (lost != 0) begin
        push_ev(3'b010, '0, c);
        m_hunt = 0;
      end else begin
        m_vcnt++;
        if (m_vcnt > MAX) begin
          push_ev(3'b110, '0, c);
          m_hunt = 0;
        end else begin
          for (int i = 0; i < LANE_N; i++) if (am[i] && m_arr[i] < 0) m_arr[i] = m_vcnt;
          if (all_arrived()) begin
            push_ev(3'b001, model_delays(), c);
            m_hunt = 0;
            m_lock = 1;
          end
        end
      end
    end else if (am != 0) begin
      m_vcnt = 0;
      for (int i = 0; i < LANE_N; i++) m_arr[i] = am[i] ? 0 : -1;
      if (all_arrived()) begin
        push_ev(3'b001, model_delays(), c);
        m_lock = 1;
      end else begin
        m_hunt = 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [LANE_N-1:0] am, input logic [LANE_N-1:0] lost);
    @(posedge clk);
    #1;
    reset                = 1'b0;
    bus.valid_i          = v;
    bus.am_v_i           = am;
    bus.am_lock_lost_v_i = lost;
    model_step(v, am, lost, cyc);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset                = 1'b1;
    bus.valid_i          = 1'b0;
    bus.am_v_i           = '0;
    bus.am_lock_lost_v_i = '0;
    m_hunt = 0;
    m_lock = 0;
    @(posedge clk);
    #1;
    chk("rst_align_v", 32'(bus.align_v_o), 32'd0);
    chk("rst_delay", 32'(bus.delay_sel_o), 32'd0);
    chk("rst_err", 32'(bus.align_err_o), 32'd0);
    chk("rst_drst", 32'(bus.deskew_rst_o), 32'd0);
  endtask

  // sk[i] = block slot of lane i's marker, -1 = never; valid-low slots hold garbage markers.
  task automatic run_scn(input int sk[LANE_N], input int gap_at, input int gap_len,
                         input int lost_at, input logic [LANE_N-1:0] lost_mask, input bit rnd_gaps);
    for (int t = 0; t < 35; t++) begin
      logic [LANE_N-1:0] am;
      am = '0;
      if (t == gap_at) repeat (gap_len) drive(1'b0, LANE_N'($urandom), '0);
      if (rnd_gaps && $urandom_range(0, 4) == 0) drive(1'b0, LANE_N'($urandom), '0);
      for (int i = 0; i < LANE_N; i++) am[i] = (sk[i] == t);
      drive(1'b1, am, (t == lost_at) ? lost_mask : '0);
    end
  endtask

  task automatic end_scn();
    drive(1'b1, '0, 4'b1000);
    drive(1'b1, '0, '0);
    drive(1'b1, '0, '0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic prev_align = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] act_w, exp_w;
    logic rise;
    rise = bus.align_v_o && !prev_align;
    if (bus.align_err_o || bus.deskew_rst_o || rise) begin
      act_w = {bus.align_err_o, bus.deskew_rst_o, rise, bus.delay_sel_o, 16'(cyc)};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL event: unexpected event got %h expected none", act_w);
      end else begin
        exp_w = exp_q.pop_front();
        if (act_w !== exp_w) begin
          failures++;
          $display("FAIL event: got %h expected %h", act_w, exp_w);
        end
      end
    end
    if (!bus.align_v_o && bus.delay_sel_o != 0) begin
      checks++;
      failures++;
      $display("FAIL delay_idle: got %h expected 0", bus.delay_sel_o);
    end
    prev_align = bus.align_v_o;
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.valid_i          = 1'b0;
    bus.am_v_i           = '0;
    bus.am_lock_lost_v_i = '0;
    do_reset();

    // skews {0,3,1,4}
    run_scn('{0, 3, 1, 4}, -1, 0, -1, '0, 1'b0);
    chk("skew_0314_v", 32'(bus.align_v_o), 32'd1);
    chk("skew_0314_dly", 32'(bus.delay_sel_o), 32'({5'd0, 5'd3, 5'd1, 5'd4}));
    end_scn();

    // all lanes in one slot
    run_scn('{0, 0, 0, 0}, -1, 0, -1, '0, 1'b0);
    chk("same_slot_dly", 32'(bus.delay_sel_o), 32'd0);
    end_scn();

    // one marker only: skew limit overrun
    run_scn('{0, -1, -1, -1}, -1, 0, -1, '0, 1'b0);
    chk("overrun_v", 32'(bus.align_v_o), 32'd0);
    end_scn();

    // lock lost while aligned, then relock
    run_scn('{0, 3, 1, 4}, -1, 0, 10, 4'b0010, 1'b0);
    chk("lost_v", 32'(bus.align_v_o), 32'd0);
    run_scn('{2, 0, 0, 1}, -1, 0, -1, '0, 1'b0);
    chk("relock_dly", 32'(bus.delay_sel_o), 32'({5'd1, 5'd2, 5'd2, 5'd0}));
    end_scn();

    // valid gap mid-count
    run_scn('{0, 2, 2, 1}, 1, 3, -1, '0, 1'b0);
    chk("gap_dly", 32'(bus.delay_sel_o), 32'({5'd1, 5'd0, 5'd0, 5'd2}));
    end_scn();

    // lock lost together with the completing marker
    run_scn('{0, 1, 1, 2}, -1, 0, 2, 4'b0001, 1'b0);
    chk("lost_last_v", 32'(bus.align_v_o), 32'd0);
    end_scn();

    // reset mid-count
    drive(1'b1, 4'b0001, '0);
    repeat (3) drive(1'b1, '0, '0);
    do_reset();

    // randomized skew sets
    for (int n = 0; n < 25; n++) begin
      int sk[LANE_N];
      int r, mn, lost_at;
      bit any;
      any = 0;
      for (int i = 0; i < LANE_N; i++) begin
        r = int'($urandom_range(0, 15));
        if (r == 0) sk[i] = -1;
        else if (r == 1) sk[i] = int'($urandom_range(MAX + 1, MAX + 4));
        else sk[i] = int'($urandom_range(0, MAX));
        if (sk[i] >= 0) any = 1;
      end
      if (!any) sk[0] = 0;
      mn = 1000;
      for (int i = 0; i < LANE_N; i++) if (sk[i] >= 0 && sk[i] < mn) mn = sk[i];
      for (int i = 0; i < LANE_N; i++) if (sk[i] >= 0) sk[i] = sk[i] - mn;
      lost_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 30)) : -1;
      run_scn(sk, -1, 0, lost_at, LANE_N'($urandom_range(1, 15)), 1'b1);
      end_scn();
    end

    repeat (5) drive(1'b1, '0, '0);
    @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/deskew_ctrl_rx.md
DESKEW_CTRL_RX -- requirements
Module: deskew_ctrl_rx

Interface
REQ-001 SHALL have parameter LANE_N, default 4, number of PCS lanes.
REQ-002 SHALL have parameter MAX_SKEW_BLOCK_N, default 27, largest correctable inter-lane skew in 66-bit blocks.
REQ-003 SHALL have parameter DLY_W, default 5, delay select width per lane; DLY_W SHALL satisfy 2^DLY_W > MAX_SKEW_BLOCK_N.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 valid_i  in  1  block slot valid; when low, all state holds.
REQ-008 am_v_i  in  LANE_N  alignment marker seen on lane i this cycle.
REQ-009 am_lock_lost_v_i  in  LANE_N  marker lock lost on lane i; one-cycle pulse.
REQ-010 delay_sel_o  out  LANE_N*DLY_W  per-lane delay, in blocks, applied by the deskew datapath; lane i at [i*DLY_W +: DLY_W].
REQ-011 align_v_o  out  1  all lanes deskewed, delays valid.
REQ-012 align_err_o  out  1  one-cycle pulse: skew exceeded MAX_SKEW_BLOCK_N.
REQ-013 deskew_rst_o  out  1  one-cycle pulse: datapath delay lines must flush.

Function
REQ-014 FSM states SHALL be IDLE, COUNT and ALIGNED.
REQ-015 In IDLE, on a cycle with valid_i=1 and am_v_i!=0, the FSM SHALL go to COUNT, clear skew counter cnt to 0, and capture arr[i]=0 for every lane with am_v_i[i]=1.
REQ-016 In COUNT, each valid_i=1 cycle SHALL increment cnt by 1; a lane not yet captured with am_v_i[i]=1 SHALL capture arr[i]=cnt+1, i.e. the new cnt value.
REQ-017 A repeated am_v_i on an already captured lane SHALL be ignored.
REQ-018 When all lanes are captured, the FSM SHALL go to ALIGNED; on the next cycle delay_sel_o lane i SHALL equal cnt_final - arr[i], so the latest lane gets 0.
REQ-019 align_v_o SHALL assert in the same cycle delay_sel_o updates (1 cycle after the completing marker), and SHALL stay high while in ALIGNED.
REQ-020 If all lanes see am_v_i in the same IDLE cycle, the FSM SHALL reach ALIGNED with all delays 0.
REQ-021 If cnt would exceed MAX_SKEW_BLOCK_N in COUNT, the FSM SHALL pulse align_err_o and deskew_rst_o for one cycle and return to IDLE.
REQ-022 Any am_lock_lost_v_i bit in COUNT or ALIGNED SHALL return the FSM to IDLE, clear delay_sel_o to 0, deassert align_v_o, and pulse deskew_rst_o, all on the next cycle.
REQ-023 A lock-lost pulse SHALL take priority over marker capture and completion in the same cycle.
REQ-024 In IDLE, lock-lost pulses SHALL be ignored.
REQ-025 When valid_i=0, cnt, arr, state and outputs SHALL hold; pulses SHALL still last exactly one cycle.
REQ-026 cnt SHALL saturate logic-wise at MAX_SKEW_BLOCK_N+1 and never wrap.

Reset
REQ-027 On reset: state=IDLE, cnt=0, arr=0, delay_sel_o=0, align_v_o=0, align_err_o=0, deskew_rst_o=0.
REQ-028 Reset asserted mid-COUNT or mid-ALIGNED SHALL give the REQ-027 values on the next edge, with no deskew_rst_o pulse.

Structure
REQ-029 The shared PCS package SHALL hold the FSM state enum, LANE_N, BLOCK_W=66, MAX_SKEW_BIT_N=1856, and MAX_SKEW_BLOCK_N=(MAX_SKEW_BIT_N-BLOCK_W-1)/BLOCK_W.
REQ-030 A per-lane sub-module deskew_ctrl_lane_rx SHALL hold the capture flag and arr register, instantiated LANE_N times; the FSM and cnt SHALL be in the top.

Verification
REQ-031 Markers arrive at skews {0,3,1,4} blocks, valid_i=1 -> align_v_o rises 1 cycle after the lane-3 marker; delay_sel_o={4,1,3,0}.
REQ-032 All four markers arrive in one cycle -> align_v_o next cycle; all delays 0.
REQ-033 Lane 0 marker arrives, then nothing for 28 valid cycles -> align_err_o and deskew_rst_o pulse once, FSM returns to IDLE, align_v_o stays 0.
REQ-034 In ALIGNED, am_lock_lost_v_i=4'b0010 -> next cycle align_v_o=0, delay_sel_o=0, one deskew_rst_o pulse; a new skew set {2,0,0,1} relocks with delays {0,2,2,1}.
REQ-035 Skews {0,2,2,1} with valid_i low 3 cycles mid-COUNT -> delays unchanged versus the no-gap run.
REQ-036 Lock-lost coincides with the last marker -> FSM returns to IDLE, align_v_o never asserts; reset mid-COUNT -> all outputs 0, no pulse.
